fifo_uart_tx: RTL and testbench

Serial transmit stage that sits directly downstream of the synchronous FIFO and drains it. When enabled and the FIFO is non-empty, it pops one word, then shifts it out on a single-wire asynchronous serial line. The frame is a start bit, DATA_WIDTH data bits LSB-first, an optional parity bit and 1 or 2 stop bits, each CLKS_PER_BIT clocks long. The block connects to the FIFO's read side: rd_en, empty, and the registered data_out.

---
 rtl/fifo_uart_tx.sv | 177 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drains a synchronous FIFO and transmits each word as an asynchronous serial
// frame: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, then
// STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks.
//
// Ports:
//   clk         rising-edge clock for all logic
//   rst_n       synchronous active-low reset
//   enable      allows fetching a new word; a frame in flight always completes
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO registered data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en  one-cycle pop request, only ever asserted in IDLE
//   tx          registered serial line, idles high
//   busy        registered, high in every state except IDLE
//   frame_done  registered, one-cycle pulse on the last cycle of the final stop bit
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line high; pop a word when enabled and the FIFO is non-empty
// FETCH  | capture fifo_data into the shift register, compute parity
// START  | start bit (tx=0) for one bit time
// DATA   | DATA_WIDTH data bits, LSB first
// PARITY | parity bit (only reachable when PARITY_EN=1)
// STOP   | STOP_BITS bit times of tx=1, then back to IDLE

module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  baud_tc;

    always_comb begin
        state_d    = state_q;
        baud_d     = '0;
        bit_d      = bit_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        baud_tc    = (baud_q == BAUD_LAST);
        fifo_rd_en = (state_q == S_IDLE) && enable && !fifo_empty;

        case (state_q)
            S_IDLE: begin
                bit_d = '0;
                if (fifo_rd_en) state_d = S_FETCH;
            end
            S_FETCH: begin
                shift_d  = fifo_data;
                parity_d = (^fifo_data) ^ (PARITY_ODD != 0);
                state_d  = S_START;
            end
            S_START: begin
                if (baud_tc) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    if (bit_q == DATA_LAST) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tc) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                // bit_q counts stop bits here so 2-stop frames need no extra counter
                if (baud_tc) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Baud counter only runs in the timed states; a terminal count always
        // coincides with a bit boundary or state change, so it clears there.
        if (state_q == S_START || state_q == S_DATA ||
            state_q == S_PARITY || state_q == S_STOP) begin
            baud_d = baud_tc ? '0 : baud_q + BAUD_W'(1);
        end

        // tx is registered from the next state so it changes on the same edge
        // as the state it belongs to.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);

        // Fires one cycle early so the registered pulse lands on the last
        // cycle of the final stop bit (CLKS_PER_BIT >= 2 keeps this in STOP).
        frame_done_d = (state_q == S_STOP) && (baud_q == BAUD_PRE) &&
                       (bit_q == STOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx. Three instances with different framing options
// share clock, reset and enable; each drains its own behavioural FIFO. A
// frame-level reference model predicts tx/busy/frame_done/fifo_rd_en every
// cycle from the word popped and the bit timing rules.
//
// lane | C | parity | odd | stop bits
//   0  | 4 |   0    |  0  |    1
//   1  | 4 |   1    |  0  |    2
//   2  | 3 |   1    |  1  |    1

module tb_fifo_uart_tx;

    localparam int NL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n  = 1'b0;
    logic enable = 1'b0;

    logic [NL-1:0] rd_en, tx, busy, done, fempty;
    logic [7:0]    fdata [NL] = '{8'h00, 8'h00, 8'h00};
    logic [7:0]    fmem  [NL][64];
    int            fhead [NL] = '{0, 0, 0};
    int            ftail [NL] = '{0, 0, 0};

    int lc [NL] = '{4, 4, 3};
    int lp [NL] = '{0, 1, 1};
    int lo [NL] = '{0, 0, 1};
    int ls [NL] = '{1, 2, 1};

    int errors = 0;
    int checks = 0;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_l0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fempty[0]), .fifo_data(fdata[0]),
        .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(done[0]));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_l1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fempty[1]), .fifo_data(fdata[1]),
        .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(done[1]));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_l2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fempty[2]), .fifo_data(fdata[2]),
        .fifo_rd_en(rd_en[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(done[2]));

    // Behavioural FIFOs with registered data_out.
    always_comb begin
        for (int l = 0; l < NL; l++) fempty[l] = (fhead[l] == ftail[l]);
    end

    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (rd_en[l] === 1'b1 && fhead[l] != ftail[l]) begin
                fdata[l] <= fmem[l][fhead[l] % 64];
                fhead[l] <= fhead[l] + 1;
            end
        end
    end

    task automatic chk(input string tag, input int lane, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s lane=%0d observed=%0h expected=%0h", tag, lane, obs, exp);
        end
    endtask

    // Reference model: position within the current transfer, counted from the
    // cycle fifo_rd_en is high (pos 0). pos 1 is the fetch cycle; the frame
    // occupies pos 2 .. 1+N*C.
    logic [NL-1:0] act = '0;
    int            pos     [NL];
    logic [7:0]    word    [NL];
    int            rd_cnt  [NL] = '{0, 0, 0};
    int            done_cnt[NL] = '{0, 0, 0};
    logic          rst_seen = 1'b0;
    logic          chk_on   = 1'b0;

    function automatic int last_pos(int l);
        return 1 + (1 + 8 + lp[l] + ls[l]) * lc[l];
    endfunction

    function automatic logic exp_tx(int l, int p, logic [7:0] w);
        int k;
        if (p < 2) return 1'b1;
        k = (p - 2) / lc[l];
        if (k == 0) return 1'b0;
        if (k <= 8) return w[k-1];
        if (lp[l] != 0 && k == 9) return (^w) ^ (lo[l] != 0);
        return 1'b1;
    endfunction

    always @(posedge clk) rst_seen <= !rst_n;

    always @(negedge clk) begin
        logic e_rd;
        if (rst_seen) begin
            chk_on = 1'b1;
            act    = '0;
        end
        if (chk_on) begin
            for (int l = 0; l < NL; l++) begin
                if (act[l]) begin
                    pos[l] = pos[l] + 1;
                    if (pos[l] > last_pos(l)) act[l] = 1'b0;
                end
                if (act[l]) begin
                    chk("tx",         l, 32'(tx[l]),   32'(exp_tx(l, pos[l], word[l])));
                    chk("busy",       l, 32'(busy[l]), 32'(1));
                    chk("frame_done", l, 32'(done[l]), 32'(pos[l] == last_pos(l)));
                end else begin
                    chk("tx_idle",    l, 32'(tx[l]),   32'(1));
                    chk("busy_idle",  l, 32'(busy[l]), 32'(0));
                    chk("done_idle",  l, 32'(done[l]), 32'(0));
                end
                e_rd = !act[l] && enable && (fhead[l] != ftail[l]);
                chk("fifo_rd_en", l, 32'(rd_en[l]), 32'(e_rd));
                if (rd_en[l] === 1'b1) rd_cnt[l]++;
                if (done[l] === 1'b1) done_cnt[l]++;
                if (e_rd) begin
                    act[l]  = 1'b1;
                    pos[l]  = 0;
                    word[l] = fmem[l][fhead[l] % 64];
                end
            end
        end
    end

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int l, input logic [7:0] v);
        fmem[l][ftail[l] % 64] = v;
        ftail[l] = ftail[l] + 1;
    endtask

    task automatic push_all(input logic [7:0] v);
        for (int l = 0; l < NL; l++) push(l, v);
    endtask

    function automatic logic all_drained();
        logic r;
        r = (act == '0);
        for (int l = 0; l < NL; l++) if (fhead[l] != ftail[l]) r = 1'b0;
        return r;
    endfunction

    task automatic wait_drained(input int budget, input string tag);
        int n;
        n = 0;
        while (n < budget && !all_drained()) begin
            tick(1);
            n++;
        end
        chk(tag, -1, 32'(all_drained()), 32'(1));
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        int n;
        n = 0;
        while (n < budget && act != '0) begin
            tick(1);
            n++;
        end
        chk(tag, -1, 32'(act == '0), 32'(1));
    endtask

    int base_rd [NL];
    int base_dn [NL];

    task automatic snap();
        for (int l = 0; l < NL; l++) begin
            base_rd[l] = rd_cnt[l];
            base_dn[l] = done_cnt[l];
        end
    endtask

    initial begin
        int n;

        // Reset held for a few edges; model checks start after the first.
        tick(3);
        rst_n = 1'b1;
        tick(2);
        for (int l = 0; l < NL; l++) begin
            chk("reset_tx",   l, 32'(tx[l]),    32'(1));
            chk("reset_busy", l, 32'(busy[l]),  32'(0));
            chk("reset_rd",   l, 32'(rd_en[l]), 32'(0));
        end

        // Single word 0xA5.
        snap();
        push_all(8'hA5);
        enable = 1'b1;
        wait_drained(200, "a5_drain");
        for (int l = 0; l < NL; l++) begin
            chk("a5_rd_pulses",   l, 32'(rd_cnt[l] - base_rd[l]),   32'(1));
            chk("a5_done_pulses", l, 32'(done_cnt[l] - base_dn[l]), 32'(1));
        end

        // Back-to-back 0x00 then 0xFF.
        snap();
        push_all(8'h00);
        push_all(8'hFF);
        wait_drained(300, "b2b_drain");
        for (int l = 0; l < NL; l++) begin
            chk("b2b_rd_pulses",   l, 32'(rd_cnt[l] - base_rd[l]),   32'(2));
            chk("b2b_done_pulses", l, 32'(done_cnt[l] - base_dn[l]), 32'(2));
        end

        // Parity word 0x07.
        push_all(8'h07);
        wait_drained(200, "parity_drain");

        // enable low with three words queued, then drop enable in frame 2.
        snap();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) push_all(8'($urandom));
        tick(30);
        for (int l = 0; l < NL; l++) begin
            chk("en0_no_rd", l, 32'(rd_cnt[l] - base_rd[l]), 32'(0));
            chk("en0_tx",    l, 32'(tx[l]),                  32'(1));
        end
        enable = 1'b1;
        n = 0;
        while (n < 200 && rd_cnt[0] - base_rd[0] < 2) begin
            tick(1);
            n++;
        end
        chk("en_second_fetch", 0, 32'(rd_cnt[0] - base_rd[0]), 32'(2));
        tick(5);
        enable = 1'b0;
        wait_quiet(200, "en_drop_quiet");
        tick(10);
        chk("en_drop_rd",    0, 32'(rd_cnt[0] - base_rd[0]),   32'(2));
        chk("en_drop_done",  0, 32'(done_cnt[0] - base_dn[0]), 32'(2));
        chk("en_drop_level", 0, 32'(ftail[0] - fhead[0]),      32'(1));
        enable = 1'b1;
        wait_drained(300, "en_restore_drain");

        // Reset during data bit 3 of lane 0.
        snap();
        push_all(8'h3C);
        push_all(8'h5A);
        n = 0;
        while (n < 50 && rd_cnt[0] == base_rd[0]) begin
            tick(1);
            n++;
        end
        chk("rst_first_fetch", 0, 32'(rd_cnt[0] - base_rd[0]), 32'(1));
        tick(18);
        rst_n = 1'b0;
        tick(1);
        for (int l = 0; l < NL; l++) begin
            chk("midrst_tx",   l, 32'(tx[l]),   32'(1));
            chk("midrst_busy", l, 32'(busy[l]), 32'(0));
            chk("midrst_done", l, 32'(done[l]), 32'(0));
        end
        rst_n = 1'b1;
        wait_drained(300, "rst_refetch_drain");
        chk("rst_refetch_rd", 0, 32'(rd_cnt[0] - base_rd[0]),   32'(2));
        chk("rst_refetch_dn", 0, 32'(done_cnt[0] - base_dn[0]), 32'(1));

        // Randomized traffic with enable toggling and occasional resets.
        for (int i = 0; i < 600; i++) begin
            int l;
            tick(1);
            l = int'($urandom_range(0, NL - 1));
            if ($urandom_range(0, 5) == 0 && ftail[l] - fhead[l] < 60) push(l, 8'($urandom));
            if ($urandom_range(0, 40) == 0) enable = ~enable;
            if ($urandom_range(0, 250) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
        end
        enable = 1'b1;
        wait_drained(5000, "random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
